branch_resolver: RTL and testbench

- Consumer end of the branch-predictor prediction/resolution interface.
- Buffers each in-flight prediction (pc, history index, target, taken) in an in-order queue.
- Compares each prediction against the execute-stage outcome and emits the res_* update bundle back to the predictor.
- On a mispredict it also emits a fetch redirect and a wrong-path squash; sits between fetch and the execute/branch unit.

---
 rtl/branch_resolver.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolver.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//
// Consumer end of the branch-predictor prediction/resolution interface.
// Fetch pushes each prediction (pc, history index, target, direction) into
// an in-order queue. Execute resolves branches oldest-first. Each resolution
// is compared against the queued head. The result is returned to the
// predictor as the res_* bundle. A wrong prediction also raises a fetch
// redirect and discards the younger, wrong-path queue entries.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   flush_i             external flush: empties the queue, suppresses any
//                       resolution/push in the same cycle
//   pred_*              prediction push from fetch (valid/ready handshake)
//   exe_*               resolved outcome of the oldest branch
//   res_*               registered resolution bundle to the predictor
//   redirect_*          registered fetch restart request
//   order_err_o         sticky: resolve on empty queue or pc mismatch
//
// Optional build macro BRANCH_RESOLVER_STATS_EN adds saturating 32-bit
// counters stat_branches_o / stat_mispred_o (not cleared by flush).
// ---------------------------------------------------------------------------
module branch_resolver #(
    parameter int XLEN  = 32,
    parameter int HLEN  = 5,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    output logic            pred_ready_o,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic [HLEN-1:0] pred_index_i,
    input  logic [XLEN-1:0] pred_target_i,
    input  logic            pred_taken_i,
    input  logic            exe_valid_i,
    input  logic [XLEN-1:0] exe_pc_i,
    input  logic [XLEN-1:0] exe_target_i,
    input  logic            exe_taken_i,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_pc_o,
    output logic [HLEN-1:0] res_index_o,
    output logic [XLEN-1:0] res_target_o,
    output logic            res_taken_o,
    output logic            res_mispredict_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            order_err_o
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Prediction storage (no reset needed: validity is tracked by r_count)
    logic [XLEN-1:0] r_q_pc     [DEPTH];
    logic [HLEN-1:0] r_q_index  [DEPTH];
    logic [XLEN-1:0] r_q_target [DEPTH];
    logic            r_q_taken  [DEPTH];

    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] w_head_pc;
    logic [HLEN-1:0] w_head_index;
    logic [XLEN-1:0] w_head_target;
    logic            w_head_taken;

    logic            w_push;
    logic            w_pop;
    logic            w_empty_err;
    logic            w_pc_err;
    logic            w_dir_miss;
    logic            w_mispred;
    logic [XLEN-1:0] w_redirect_pc;

    assign pred_ready_o = (r_count != FULL_CNT);

    assign w_head_pc     = r_q_pc[r_rd_ptr];
    assign w_head_index  = r_q_index[r_rd_ptr];
    assign w_head_target = r_q_target[r_rd_ptr];
    assign w_head_taken  = r_q_taken[r_rd_ptr];

    always_comb begin
        w_pop       = ~flush_i & exe_valid_i & (r_count != '0);
        w_empty_err = ~flush_i & exe_valid_i & (r_count == '0);
        w_pc_err    = w_pop & (exe_pc_i != w_head_pc);
        // Target only matters when the branch was actually taken
        w_dir_miss  = (exe_taken_i != w_head_taken)
                    | (exe_taken_i & (exe_target_i != w_head_target));
        // A pc mismatch means the queue is out of sync with execute, so it
        // is treated as a mispredict to force a clean restart.
        w_mispred   = w_pop & (w_dir_miss | w_pc_err);
        // A push racing a mispredict is wrong-path and is dropped
        w_push      = ~flush_i & ~w_mispred & pred_valid_i & pred_ready_o;
        w_redirect_pc = exe_taken_i ? exe_target_i : (exe_pc_i + XLEN'(4));
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]     <= pred_pc_i;
            r_q_index[r_wr_ptr]  <= pred_index_i;
            r_q_target[r_wr_ptr] <= pred_target_i;
            r_q_taken[r_wr_ptr]  <= pred_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            res_valid_o      <= 1'b0;
            res_pc_o         <= '0;
            res_index_o      <= '0;
            res_target_o     <= '0;
            res_taken_o      <= 1'b0;
            res_mispredict_o <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            order_err_o      <= 1'b0;
        end else begin
            res_valid_o      <= w_pop;
            redirect_valid_o <= w_mispred;

            if (w_pop) begin
                res_pc_o         <= exe_pc_i;
                res_index_o      <= w_head_index;
                res_target_o     <= exe_target_i;
                res_taken_o      <= exe_taken_i;
                res_mispredict_o <= w_mispred;
            end

            if (w_mispred) begin
                redirect_pc_o <= w_redirect_pc;
            end

            if (w_empty_err | w_pc_err) begin
                order_err_o <= 1'b1;
            end

            if (flush_i | w_mispred) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            if (w_pop && (stat_branches_o != 32'hFFFF_FFFF)) begin
                stat_branches_o <= stat_branches_o + 32'd1;
            end
            if (w_mispred && (stat_mispred_o != 32'hFFFF_FFFF)) begin
                stat_mispred_o <= stat_mispred_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//
// Directed self-checking bench for branch_resolver (XLEN=32, HLEN=5,
// DEPTH=4). Inputs change and outputs are sampled 1 time unit after the
// rising edge. Build with +define+BRANCH_RESOLVER_STATS_EN to also check
// the statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

    localparam int XLEN  = 32;
    localparam int HLEN  = 5;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            flush_i;
    logic            pred_valid_i;
    logic            pred_ready_o;
    logic [XLEN-1:0] pred_pc_i;
    logic [HLEN-1:0] pred_index_i;
    logic [XLEN-1:0] pred_target_i;
    logic            pred_taken_i;
    logic            exe_valid_i;
    logic [XLEN-1:0] exe_pc_i;
    logic [XLEN-1:0] exe_target_i;
    logic            exe_taken_i;
    logic            res_valid_o;
    logic [XLEN-1:0] res_pc_o;
    logic [HLEN-1:0] res_index_o;
    logic [XLEN-1:0] res_target_o;
    logic            res_taken_o;
    logic            res_mispredict_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            order_err_o;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0]     stat_branches_o;
    logic [31:0]     stat_mispred_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    branch_resolver #(
        .XLEN (XLEN),
        .HLEN (HLEN),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .pred_valid_i    (pred_valid_i),
        .pred_ready_o    (pred_ready_o),
        .pred_pc_i       (pred_pc_i),
        .pred_index_i    (pred_index_i),
        .pred_target_i   (pred_target_i),
        .pred_taken_i    (pred_taken_i),
        .exe_valid_i     (exe_valid_i),
        .exe_pc_i        (exe_pc_i),
        .exe_target_i    (exe_target_i),
        .exe_taken_i     (exe_taken_i),
        .res_valid_o     (res_valid_o),
        .res_pc_o        (res_pc_o),
        .res_index_o     (res_index_o),
        .res_target_o    (res_target_o),
        .res_taken_o     (res_taken_o),
        .res_mispredict_o(res_mispredict_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .order_err_o     (order_err_o)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_branches_o (stat_branches_o),
        .stat_mispred_o  (stat_mispred_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pred(input logic [XLEN-1:0] pc, input logic [HLEN-1:0] idx,
                            input logic [XLEN-1:0] tgt, input logic tkn);
        pred_valid_i  = 1'b1;
        pred_pc_i     = pc;
        pred_index_i  = idx;
        pred_target_i = tgt;
        pred_taken_i  = tkn;
    endtask

    task automatic set_exe(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                           input logic tkn);
        exe_valid_i  = 1'b1;
        exe_pc_i     = pc;
        exe_target_i = tgt;
        exe_taken_i  = tkn;
    endtask

    task automatic idle_inputs();
        pred_valid_i = 1'b0;
        exe_valid_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic push_one(input logic [XLEN-1:0] pc, input logic [HLEN-1:0] idx,
                            input logic [XLEN-1:0] tgt, input logic tkn);
        set_pred(pc, idx, tgt, tkn);
        tick();
        idle_inputs();
    endtask

    task automatic resolve(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                           input logic tkn);
        set_exe(pc, tgt, tkn);
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        #1;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        idle_inputs();
        pred_pc_i = '0; pred_index_i = '0; pred_target_i = '0; pred_taken_i = 1'b0;
        exe_pc_i = '0; exe_target_i = '0; exe_taken_i = 1'b0;
        #7;
        chk("rst_ready",     pred_ready_o,     1);
        chk("rst_res_valid", res_valid_o,      0);
        chk("rst_redirect",  redirect_valid_o, 0);
        chk("rst_order_err", order_err_o,      0);
        chk("rst_res_pc",    res_pc_o,         0);
        chk("rst_redir_pc",  redirect_pc_o,    0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Correct taken prediction
        push_one(32'h100, 5'd3, 32'h200, 1'b1);
        resolve(32'h100, 32'h200, 1'b1);
        chk("t1_res_valid", res_valid_o,      1);
        chk("t1_res_pc",    res_pc_o,         32'h100);
        chk("t1_res_index", res_index_o,      3);
        chk("t1_res_target",res_target_o,     32'h200);
        chk("t1_res_taken", res_taken_o,      1);
        chk("t1_mispred",   res_mispredict_o, 0);
        chk("t1_redirect",  redirect_valid_o, 0);
        tick();
        chk("t1_pulse",     res_valid_o,      0);
        chk("t1_hold_pc",   res_pc_o,         32'h100);

        // Predicted not-taken, actually taken; younger entries squashed
        push_one(32'h100, 5'd1, 32'h0,   1'b0);
        push_one(32'h104, 5'd2, 32'h0,   1'b0);
        push_one(32'h108, 5'd3, 32'h0,   1'b0);
        set_pred(32'h10C, 5'd4, 32'h0, 1'b0);
        resolve(32'h100, 32'h180, 1'b1);
        chk("t2_res_valid", res_valid_o,      1);
        chk("t2_mispred",   res_mispredict_o, 1);
        chk("t2_redirect",  redirect_valid_o, 1);
        chk("t2_redir_pc",  redirect_pc_o,    32'h180);
        chk("t2_res_index", res_index_o,      1);
        tick();
        chk("t2_redir_pulse", redirect_valid_o, 0);
        chk("t2_redir_hold",  redirect_pc_o,    32'h180);

        // Fill to DEPTH from empty, drop while full, pop+push across wrap
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("t4_ready_pre%0d", i), pred_ready_o, 1);
            push_one(32'h300 + 32'(4 * i), 5'(i), 32'h0, 1'b0);
        end
        chk("t4_full_ready", pred_ready_o, 0);
        push_one(32'h3F0, 5'd7, 32'h0, 1'b0);
        chk("t4_drop_ready", pred_ready_o, 0);
        resolve(32'h300, 32'h0, 1'b0);
        chk("t4_pop0_idx",   res_index_o,      0);
        chk("t4_pop0_mis",   res_mispredict_o, 0);
        chk("t4_pop0_ready", pred_ready_o,     1);
        set_pred(32'h310, 5'd4, 32'h0, 1'b0);
        resolve(32'h304, 32'h0, 1'b0);
        chk("t4_pp_idx",     res_index_o,      1);
        chk("t4_pp_mis",     res_mispredict_o, 0);
        chk("t4_pp_ready",   pred_ready_o,     1);
        push_one(32'h314, 5'd5, 32'h0, 1'b0);
        chk("t4_refull",     pred_ready_o,     0);
        for (int i = 2; i < 6; i++) begin
            resolve(32'h300 + 32'(4 * i), 32'h0, 1'b0);
            chk($sformatf("t4_drain%0d_valid", i), res_valid_o,      1);
            chk($sformatf("t4_drain%0d_idx", i),   res_index_o,      i);
            chk($sformatf("t4_drain%0d_mis", i),   res_mispredict_o, 0);
        end
        chk("t4_empty_ready", pred_ready_o, 1);

        // Predicted taken, actually not taken -> restart at pc+4
        push_one(32'h100, 5'd2, 32'h200, 1'b1);
        resolve(32'h100, 32'h200, 1'b0);
        chk("t3_mispred",   res_mispredict_o, 1);
        chk("t3_redirect",  redirect_valid_o, 1);
        chk("t3_redir_pc",  redirect_pc_o,    32'h104);
        chk("t3_res_taken", res_taken_o,      0);

        // Taken both ways but wrong target
        push_one(32'h400, 5'd6, 32'h500, 1'b1);
        resolve(32'h400, 32'h520, 1'b1);
        chk("tt_mispred",  res_mispredict_o, 1);
        chk("tt_redir_pc", redirect_pc_o,    32'h520);

        // Not taken both ways: target ignored
        push_one(32'h440, 5'd8, 32'h999, 1'b0);
        resolve(32'h440, 32'h123, 1'b0);
        chk("nt_mispred",  res_mispredict_o, 0);
        chk("nt_redirect", redirect_valid_o, 0);
        chk("nt_err",      order_err_o,      0);

        // Wrap-around pc+4 for not-taken mispredict at top of address space
        push_one(32'hFFFF_FFFC, 5'd9, 32'h40, 1'b1);
        resolve(32'hFFFF_FFFC, 32'h40, 1'b0);
        chk("wrap_redir_pc", redirect_pc_o, 32'h0);

        // pc mismatch: popped, reported as mispredict, error latched
        push_one(32'h600, 5'd10, 32'h700, 1'b1);
        resolve(32'h604, 32'h700, 1'b1);
        chk("pcm_valid",    res_valid_o,      1);
        chk("pcm_mispred",  res_mispredict_o, 1);
        chk("pcm_redirect", redirect_valid_o, 1);
        chk("pcm_redir_pc", redirect_pc_o,    32'h700);
        chk("pcm_err",      order_err_o,      1);

        // Asynchronous reset mid-operation (queue not empty)
        push_one(32'h900, 5'd1, 32'h0, 1'b0);
        set_exe(32'h900, 32'h0, 1'b0);
        rst_n_i = 1'b0;
        #1;
        chk("arst_err",       order_err_o,  0);
        chk("arst_res_pc",    res_pc_o,     0);
        chk("arst_ready",     pred_ready_o, 1);
        chk("arst_res_valid", res_valid_o,  0);
        idle_inputs();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Resolve with empty queue
        resolve(32'h0, 32'h0, 1'b0);
        chk("emp_valid",    res_valid_o,      0);
        chk("emp_redirect", redirect_valid_o, 0);
        chk("emp_err",      order_err_o,      1);
        push_one(32'hA00, 5'd9, 32'hB00, 1'b1);
        resolve(32'hA00, 32'hB00, 1'b1);
        chk("emp_ok_valid", res_valid_o,      1);
        chk("emp_ok_mis",   res_mispredict_o, 0);
        chk("emp_sticky",   order_err_o,      1);

        // Flush with 3 entries, racing resolve and push ignored
        push_one(32'h800, 5'd1, 32'h0, 1'b0);
        push_one(32'h804, 5'd2, 32'h0, 1'b0);
        push_one(32'h808, 5'd3, 32'h0, 1'b0);
        flush_i = 1'b1;
        set_pred(32'h80C, 5'd4, 32'h0, 1'b0);
        set_exe(32'h800, 32'h900, 1'b1);
        tick();
        idle_inputs();
        chk("fl_res_valid", res_valid_o,      0);
        chk("fl_redirect",  redirect_valid_o, 0);
        chk("fl_ready",     pred_ready_o,     1);
        chk("fl_hold_pc",   res_pc_o,         32'hA00);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fl_ready_pre%0d", i), pred_ready_o, 1);
            push_one(32'hC00 + 32'(4 * i), 5'(16 + i), 32'h0, 1'b0);
        end
        chk("fl_full", pred_ready_o, 0);
        resolve(32'hC00, 32'h0, 1'b0);
        chk("fl_first_idx", res_index_o,      16);
        chk("fl_first_mis", res_mispredict_o, 0);

`ifdef BRANCH_RESOLVER_STATS_EN
        do_reset();
        chk("st_rst_br", stat_branches_o, 0);
        chk("st_rst_mp", stat_mispred_o,  0);
        for (int i = 0; i < 10; i++) begin
            push_one(32'h1000 + 32'(8 * i), 5'(i), 32'h2000, 1'b1);
            // Resolutions 2, 5 and 8 go the wrong way
            if (i == 2 || i == 5 || i == 8) begin
                resolve(32'h1000 + 32'(8 * i), 32'h2000, 1'b0);
            end else begin
                resolve(32'h1000 + 32'(8 * i), 32'h2000, 1'b1);
            end
        end
        tick();
        chk("st_branches", stat_branches_o, 10);
        chk("st_mispred",  stat_mispred_o,  3);
        push_one(32'h3000, 5'd0, 32'h0, 1'b0);
        flush_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("st_fl_br", stat_branches_o, 10);
        chk("st_fl_mp", stat_mispred_o,  3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
